vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_pkg.sv | 40 ++++
 rtl/vend_if.sv | 34 +++
 rtl/vend_credit_acc.sv | 50 +++++
 rtl/vend_controller.sv | 133 +++++++++++++
 tb/tb_vend_controller.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types, coin/selection encodings and pricing
// for the coffee vending controller.
package vend_pkg;

  localparam int CREDIT_W_DEF = 5;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_COLLECT  = 3'd1;
  localparam state_t S_DISPENSE = 3'd2;
  localparam state_t S_CHANGE   = 3'd3;
  localparam state_t S_REFUND   = 3'd4;

  localparam logic [3:0] COIN_1  = 4'd1;
  localparam logic [3:0] COIN_2  = 4'd2;
  localparam logic [3:0] COIN_5  = 4'd5;
  localparam logic [3:0] COIN_10 = 4'd10;

  localparam logic [1:0] SEL_FILTER  = 2'b00;
  localparam logic [1:0] SEL_BLACK   = 2'b01;
  localparam logic [1:0] SEL_BRU     = 2'b10;
  localparam logic [1:0] SEL_NESCAFE = 2'b11;

  function automatic logic [3:0] price_of(
    input logic [1:0] sel
  );
    logic [3:0] p;
    p = 4'd0;
    unique case (sel)
      SEL_FILTER:  p = 4'd2;
      SEL_BLACK:   p = 4'd1;
      SEL_BRU:     p = 4'd5;
      SEL_NESCAFE: p = 4'd10;
      default:     p = 4'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vend_if.sv
// Customer/dispenser side signals of the vending
// controller, with master (driver) and slave views.
interface vend_if
  import vend_pkg::*;
#(
  parameter int CREDIT_W = CREDIT_W_DEF
);
  logic                coin_valid;
  logic [3:0]          coin_val;
  logic                sel_valid;
  logic [1:0]          coffee_sel;
  logic                cancel;
  logic                disp_done;
  logic                disp_req;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amt;
  logic                coin_reject;
  logic                LED_Green;
  logic                LED_Yellow;

  modport master (
    output coin_valid, coin_val, sel_valid,
    output coffee_sel, cancel, disp_done,
    input  disp_req, change_valid, change_amt,
    input  coin_reject, LED_Green, LED_Yellow
  );

  modport slave (
    input  coin_valid, coin_val, sel_valid,
    input  coffee_sel, cancel, disp_done,
    output disp_req, change_valid, change_amt,
    output coin_reject, LED_Green, LED_Yellow
  );
endinterface

// File: rtl/vend_credit_acc.sv
// Coin legality decode and credit accumulator; the
// FSM decides when coins may add and when to clear.
module vend_credit_acc
  import vend_pkg::*;
#(
  parameter int CREDIT_W = CREDIT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                add_en,
  input  logic                coin_valid,
  input  logic [3:0]          coin_val,
  output logic                coin_acc,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] credit_nxt
);

  logic coin_legal;

  // only the four denominations are accepted
  always_comb begin
    coin_legal = 1'b0;
    case (coin_val)
      COIN_1, COIN_2, COIN_5, COIN_10:
        coin_legal = 1'b1;
      default: coin_legal = 1'b0;
    endcase
  end

  assign coin_acc = coin_valid & coin_legal & add_en;

  // clear wins over add; otherwise hold
  always_comb begin
    credit_nxt = credit;
    if (clr)
      credit_nxt = '0;
    else if (coin_acc)
      credit_nxt = credit + CREDIT_W'(coin_val);
  end

  // credit register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      credit <= '0;
    else
      credit <= credit_nxt;
  end

endmodule

// File: rtl/vend_controller.sv
// Coffee vending FSM: selection, coin collection,
// dispense handshake, change and refund/timeout.
module vend_controller
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CREDIT_W       = CREDIT_W_DEF
) (
  input logic clk,
  input logic rst,
  vend_if.slave bus
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [1:0]          rst_sync;
  logic                run;
  state_t              state;
  state_t              nxt;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [TW-1:0]       timer;
  logic                coin_acc;
  logic                start;
  logic                add_en;
  logic                timeout;
  logic                disp_req_q;
  logic                chg_v_q;
  logic [CREDIT_W-1:0] chg_amt_q;
  logic                rej_q;
  logic                led_g_q;
  logic                led_y_q;

  // reset release is retimed before the FSM may move
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rst_sync <= 2'b00;
    else
      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run     = rst_sync[1];
  assign start   = (state == S_IDLE) & run & bus.sel_valid;
  assign add_en  = (state == S_COLLECT) & (credit < price);
  assign timeout = timer == TW'(TIMEOUT_CYCLES - 1);

  vend_credit_acc #(
    .CREDIT_W (CREDIT_W)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clr        (start),
    .add_en     (add_en),
    .coin_valid (bus.coin_valid),
    .coin_val   (bus.coin_val),
    .coin_acc   (coin_acc),
    .credit     (credit),
    .credit_nxt (credit_nxt)
  );

  // next state; cancel outranks price reached
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:
        if (start) nxt = S_COLLECT;
      S_COLLECT:
        if (bus.cancel)
          nxt = S_REFUND;
        else if (credit >= price)
          nxt = S_DISPENSE;
        else if (timeout && !coin_acc)
          nxt = S_REFUND;
      S_DISPENSE:
        if (bus.disp_done)
          nxt = (credit > price) ? S_CHANGE : S_IDLE;
      S_CHANGE: nxt = S_IDLE;
      S_REFUND: nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // idle timer, restarted by every accepted coin
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      timer <= '0;
    else if (state != S_COLLECT || coin_acc)
      timer <= '0;
    else
      timer <= timer + TW'(1);
  end

  // state, price and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      price      <= '0;
      disp_req_q <= 1'b0;
      led_y_q    <= 1'b0;
      led_g_q    <= 1'b1;
      chg_v_q    <= 1'b0;
      chg_amt_q  <= '0;
      rej_q      <= 1'b0;
    end else begin
      state      <= nxt;
      if (start)
        price <= CREDIT_W'(price_of(bus.coffee_sel));
      disp_req_q <= nxt == S_DISPENSE;
      led_y_q    <= nxt == S_DISPENSE;
      led_g_q    <= nxt == S_IDLE;
      rej_q      <= bus.coin_valid & ~coin_acc;
      chg_v_q    <= (nxt == S_CHANGE) |
                    ((nxt == S_REFUND) &
                     (credit_nxt != '0));
      if (nxt == S_CHANGE)
        chg_amt_q <= credit - price;
      else if (nxt == S_REFUND)
        chg_amt_q <= credit_nxt;
      else
        chg_amt_q <= '0;
    end
  end

  assign bus.disp_req     = disp_req_q;
  assign bus.LED_Yellow   = led_y_q;
  assign bus.LED_Green    = led_g_q;
  assign bus.change_valid = chg_v_q;
  assign bus.change_amt   = chg_amt_q;
  assign bus.coin_reject  = rej_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with a short
// timeout so the refund-on-idle path is reachable.
module tb_vend_controller;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total  = 0;
  int   passed = 0;
  int   n;
  logic seen;

  vend_if #(.CREDIT_W(5)) bus ();

  vend_controller #(
    .TIMEOUT_CYCLES (TO),
    .CREDIT_W       (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
  endtask

  task automatic sel(input logic [1:0] s);
    bus.sel_valid  = 1'b1;
    bus.coffee_sel = s;
    tick();
    bus.sel_valid  = 1'b0;
  endtask

  task automatic coin(input logic [3:0] v);
    bus.coin_valid = 1'b1;
    bus.coin_val   = v;
    tick();
    bus.coin_valid = 1'b0;
    bus.coin_val   = 4'd0;
  endtask

  initial begin
    bus.coin_valid = 1'b0;
    bus.coin_val   = 4'd0;
    bus.sel_valid  = 1'b0;
    bus.coffee_sel = 2'b00;
    bus.cancel     = 1'b0;
    bus.disp_done  = 1'b0;
    #12;
    chk("rst_disp_req", bus.disp_req, 0);
    chk("rst_green", bus.LED_Green, 1);
    chk("rst_yellow", bus.LED_Yellow, 0);
    chk("rst_chg_v", bus.change_valid, 0);
    chk("rst_chg_amt", bus.change_amt, 0);
    chk("rst_reject", bus.coin_reject, 0);
    chk("rst_credit", dut.credit, 0);
    chk("rst_price", dut.price, 0);
    rst = 1'b1;
    repeat (3) tick();

    // nescafe, 5+5 exact
    sel(2'b11);
    chk("n_green_off", bus.LED_Green, 0);
    coin(4'd5);
    coin(4'd5);
    chk("n_req_n1", bus.disp_req, 0);
    chk("n_credit", dut.credit, 10);
    tick();
    chk("n_req_n2", bus.disp_req, 1);
    chk("n_yellow", bus.LED_Yellow, 1);
    repeat (3) tick();
    chk("n_req_hold", bus.disp_req, 1);
    bus.disp_done = 1'b1;
    tick();
    bus.disp_done = 1'b0;
    chk("n_req_drop", bus.disp_req, 0);
    chk("n_green", bus.LED_Green, 1);
    chk("n_no_chg", bus.change_valid, 0);
    tick();
    chk("n_no_chg2", bus.change_valid, 0);

    // black Rs1, pay 10 -> change 9
    sel(2'b01);
    coin(4'd10);
    tick();
    chk("b_req", bus.disp_req, 1);
    bus.disp_done = 1'b1;
    tick();
    bus.disp_done = 1'b0;
    chk("b_chg_v", bus.change_valid, 1);
    chk("b_chg_amt", bus.change_amt, 9);
    tick();
    chk("b_chg_once", bus.change_valid, 0);
    chk("b_green", bus.LED_Green, 1);

    // bru Rs5: coin 2, then cancel with coin 1
    sel(2'b10);
    coin(4'd2);
    bus.cancel = 1'b1;
    coin(4'd1);
    bus.cancel = 1'b0;
    chk("c_chg_v", bus.change_valid, 1);
    chk("c_chg_amt", bus.change_amt, 3);
    chk("c_no_req", bus.disp_req, 0);
    tick();
    chk("c_chg_once", bus.change_valid, 0);
    chk("c_green", bus.LED_Green, 1);

    // filter, no coins: timeout, no strobe
    sel(2'b00);
    n = 0;
    seen = 1'b0;
    while (!bus.LED_Green && n < 40) begin
      tick();
      n++;
      if (bus.change_valid) seen = 1'b1;
    end
    chk("t_cycles", n, TO + 1);
    chk("t_no_chg", seen, 0);

    // filter, coin 1, timeout refunds 1
    sel(2'b00);
    coin(4'd1);
    n = 0;
    while (!bus.change_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t1_cycles", n, TO);
    chk("t1_chg_amt", bus.change_amt, 1);
    tick();
    chk("t1_green", bus.LED_Green, 1);

    // illegal coin in COLLECT, legal coin in IDLE
    sel(2'b11);
    coin(4'd3);
    chk("r_reject", bus.coin_reject, 1);
    chk("r_credit", dut.credit, 0);
    tick();
    chk("r_reject_end", bus.coin_reject, 0);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("r_no_refund", bus.change_valid, 0);
    tick();
    chk("r_idle", bus.LED_Green, 1);
    bus.disp_done = 1'b1;
    coin(4'd5);
    bus.disp_done = 1'b0;
    chk("r_idle_reject", bus.coin_reject, 1);
    chk("r_idle_credit", dut.credit, 0);
    chk("r_idle_stay", bus.LED_Green, 1);

    // reset during DISPENSE
    sel(2'b01);
    coin(4'd1);
    tick();
    chk("x_req", bus.disp_req, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("x_req_async", bus.disp_req, 0);
    chk("x_green_async", bus.LED_Green, 1);
    tick();
    rst = 1'b1;
    chk("x_credit", dut.credit, 0);
    chk("x_no_chg", bus.change_valid, 0);
    bus.sel_valid = 1'b1;
    tick();
    chk("x_sync1", bus.LED_Green, 1);
    tick();
    chk("x_sync2", bus.LED_Green, 1);
    tick();
    bus.sel_valid = 1'b0;
    chk("x_run", bus.LED_Green, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
